// File: rtl/x_mul_pkg.sv
// Shared parameters and helpers for the shift-add multiplier (x_datapath, x_fsm).
package x_mul_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREG  = 5;

  // True when v is all-zero or has exactly one bit set.
  function automatic logic onehot0(input logic [31:0] v);
    return (v & (v - 32'd1)) == 32'd0;
  endfunction

endpackage

// File: rtl/x_datapath_if.sv
// Controller-to-datapath strobe bundle: load port, register selects, step strobes, status back.
interface x_datapath_if import x_mul_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREG  = DEF_NREG
);

  logic                 ld_en;
  logic [NREG-1:0]      ld_sel;
  logic [WIDTH-1:0]     ld_data;
  logic [NREG-1:0]      rd_enA;
  logic [NREG-1:0]      rd_enB;
  logic [NREG-1:0]      wr_en;
  logic                 ppgen_en;
  logic                 add_en;
  logic                 shift_en;
  logic                 left_right;
  logic [2*WIDTH-1:0]   product;
  logic                 step_done;
  logic                 err;

  modport master (
    output ld_en, ld_sel, ld_data, rd_enA, rd_enB, wr_en,
           ppgen_en, add_en, shift_en, left_right,
    input  product, step_done, err
  );

  modport slave (
    input  ld_en, ld_sel, ld_data, rd_enA, rd_enB, wr_en,
           ppgen_en, add_en, shift_en, left_right,
    output product, step_done, err
  );

endinterface

// File: rtl/x_regfile.sv
// NREG x WIDTH operand register file: one write port, two one-hot read ports.
module x_regfile import x_mul_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREG  = DEF_NREG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [NREG-1:0]  wsel,
  input  logic [WIDTH-1:0] wdata,
  input  logic [NREG-1:0]  rsel_a,
  input  logic [NREG-1:0]  rsel_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < NREG; i++)
        if (wsel[i]) regs[i] <= wdata;
    end
  end

  // Reads come straight off the flops, so a same-cycle write is seen only after the edge.
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    for (int i = 0; i < NREG; i++) begin
      if (rsel_a[i]) rdata_a = rdata_a | regs[i];
      if (rsel_b[i]) rdata_b = rdata_b | regs[i];
    end
  end

endmodule

// File: rtl/x_datapath.sv
// Shift-add multiplier datapath: executes x_fsm strobes on PP/ACC/step, flags protocol errors.
module x_datapath import x_mul_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREG  = DEF_NREG
) (
  input  logic      clk,
  input  logic      rst,
  x_datapath_if.slave bus
);

  localparam int SW = $clog2(WIDTH + 1);
  localparam int AW = 2*WIDTH + 1;

  logic [WIDTH-1:0]   pp, pp_n;
  logic [AW-1:0]      acc, acc_n;
  logic [SW-1:0]      step, step_n;
  logic               lr_q, lr_n;
  logic               err_q;

  logic [WIDTH-1:0]   a_op, b_op;
  logic [SW-1:0]      bidx;
  logic               bsel;
  logic [WIDTH:0]     hi_sum;
  logic [2*WIDTH-1:0] prod_view;
  logic [2:0]         n_ops;
  logic               bad_sel, ld_zero, multi, shift_full, dir_change, viol;
  logic               rf_we;
  logic [NREG-1:0]    rf_sel;
  logic [WIDTH-1:0]   rf_data;

  x_regfile #(.WIDTH(WIDTH), .NREG(NREG)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .wsel    (rf_sel),
    .wdata   (rf_data),
    .rsel_a  (bus.rd_enA),
    .rsel_b  (bus.rd_enB),
    .rdata_a (a_op),
    .rdata_b (b_op)
  );

  always_comb begin
    bad_sel    = !onehot0(32'(bus.rd_enA)) || !onehot0(32'(bus.rd_enB)) ||
                 !onehot0(32'(bus.wr_en))  || !onehot0(32'(bus.ld_sel));
    ld_zero    = bus.ld_en && (bus.ld_sel == '0);
    n_ops      = 3'(bus.ppgen_en) + 3'(bus.add_en) + 3'(bus.shift_en) +
                 3'(|bus.wr_en) + 3'(bus.ld_en);
    multi      = n_ops > 3'd1;
    shift_full = bus.shift_en && (step == SW'(WIDTH));
    dir_change = (bus.left_right != lr_q) && (step != '0);
    viol       = bad_sel || ld_zero || multi || shift_full || dir_change;
  end

  // MSB-first walks B from the top bit down; an out-of-range index yields a zero mask.
  always_comb begin
    bidx      = bus.left_right ? (SW'(WIDTH - 1) - step) : step;
    bsel      = |(b_op & (WIDTH'(1) << bidx));
    hi_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, pp};
    prod_view = lr_q ? acc[AW-1:1] : acc[2*WIDTH-1:0];
  end

  always_comb begin
    pp_n   = pp;
    acc_n  = acc;
    step_n = step;
    lr_n   = lr_q;
    if (!viol) begin
      if (step == '0) lr_n = bus.left_right;
      if (|bus.wr_en) begin
        pp_n   = '0;
        acc_n  = '0;
        step_n = '0;
      end else if (bus.ppgen_en) begin
        pp_n = bsel ? a_op : '0;
      end else if (bus.add_en) begin
        acc_n = bus.left_right ? (acc + AW'(pp)) : {hi_sum, acc[WIDTH-1:0]};
      end else if (bus.shift_en) begin
        acc_n  = bus.left_right ? (acc << 1) : (acc >> 1);
        step_n = step + SW'(1);
      end
    end
  end

  always_comb begin
    rf_we   = !viol && (bus.ld_en || (|bus.wr_en));
    rf_sel  = bus.ld_en ? bus.ld_sel : bus.wr_en;
    rf_data = bus.ld_en ? bus.ld_data : prod_view[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pp    <= '0;
      acc   <= '0;
      step  <= '0;
      lr_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      pp    <= pp_n;
      acc   <= acc_n;
      step  <= step_n;
      lr_q  <= lr_n;
      err_q <= err_q | viol;
    end
  end

  assign bus.product   = prod_view;
  assign bus.step_done = (step == SW'(WIDTH));
  assign bus.err       = err_q;

endmodule

// File: tb/tb_x_datapath.sv
// Directed bench for x_datapath: table of full multiplies plus hand-written error/reset sequences.
module tb_x_datapath;
  import x_mul_pkg::*;

  localparam int W = 8;
  localparam int N = 5;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           lr;
    logic [2*W-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs [8];

  always #5 clk = ~clk;

  x_datapath_if #(.WIDTH(W), .NREG(N)) bus ();

  x_datapath #(.WIDTH(W), .NREG(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.ld_en    = 1'b0;
    bus.ld_sel   = '0;
    bus.ld_data  = '0;
    bus.wr_en    = '0;
    bus.ppgen_en = 1'b0;
    bus.add_en   = 1'b0;
    bus.shift_en = 1'b0;
  endtask

  // Inputs set before the call are sampled on the next edge, then strobes drop.
  task automatic tick();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    bus.rd_enA     = '0;
    bus.rd_enB     = '0;
    bus.left_right = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic apply_stimulus_load(input logic [N-1:0] sel, input logic [W-1:0] d);
    bus.ld_en   = 1'b1;
    bus.ld_sel  = sel;
    bus.ld_data = d;
    tick();
  endtask

  task automatic apply_stimulus_triple();
    bus.ppgen_en = 1'b1; tick();
    bus.add_en   = 1'b1; tick();
    bus.shift_en = 1'b1; tick();
  endtask

  task automatic setup_operands(input logic [W-1:0] a, input logic [W-1:0] b, input logic lr);
    do_reset();
    apply_stimulus_load(5'b00001, a);
    apply_stimulus_load(5'b00010, b);
    bus.rd_enA     = 5'b00001;
    bus.rd_enB     = 5'b00010;
    bus.left_right = lr;
  endtask

  initial begin
    vecs[0] = '{a: 8'd13,  b: 8'd11,  lr: 1'b0, exp: 16'd143};
    vecs[1] = '{a: 8'd13,  b: 8'd11,  lr: 1'b1, exp: 16'd143};
    vecs[2] = '{a: 8'd255, b: 8'd255, lr: 1'b0, exp: 16'd65025};
    vecs[3] = '{a: 8'd255, b: 8'd255, lr: 1'b1, exp: 16'd65025};
    vecs[4] = '{a: 8'd13,  b: 8'd0,   lr: 1'b0, exp: 16'd0};
    vecs[5] = '{a: 8'd0,   b: 8'd255, lr: 1'b1, exp: 16'd0};
    vecs[6] = '{a: 8'd7,   b: 8'd9,   lr: 1'b0, exp: 16'd63};
    vecs[7] = '{a: 8'd200, b: 8'd3,   lr: 1'b1, exp: 16'd600};

    idle_inputs();
    bus.rd_enA     = '0;
    bus.rd_enB     = '0;
    bus.left_right = 1'b0;
    #2;
    check_output("reset product", 32'(bus.product), 0);
    check_output("reset step_done", 32'(bus.step_done), 0);
    check_output("reset err", 32'(bus.err), 0);

    // Full multiplies, checking step_done timing and the write-back clear.
    for (int i = 0; i < 8; i++) begin
      setup_operands(vecs[i].a, vecs[i].b, vecs[i].lr);
      for (int k = 0; k < W - 1; k++) apply_stimulus_triple();
      bus.ppgen_en = 1'b1; tick();
      bus.add_en   = 1'b1; tick();
      check_output($sformatf("vec%0d step_done early", i), 32'(bus.step_done), 0);
      bus.shift_en = 1'b1; tick();
      check_output($sformatf("vec%0d step_done", i), 32'(bus.step_done), 1);
      check_output($sformatf("vec%0d product", i), 32'(bus.product), 32'(vecs[i].exp));
      check_output($sformatf("vec%0d err", i), 32'(bus.err), 0);
      bus.wr_en = 5'b00100; tick();
      check_output($sformatf("vec%0d wb product", i), 32'(bus.product), 0);
      check_output($sformatf("vec%0d wb step_done", i), 32'(bus.step_done), 0);
    end

    // Write-back lands in R2: multiply R2 by R3=1 to read it back.
    setup_operands(8'd13, 8'd11, 1'b0);
    for (int k = 0; k < W; k++) apply_stimulus_triple();
    bus.wr_en = 5'b00100; tick();
    apply_stimulus_load(5'b01000, 8'd1);
    bus.rd_enA = 5'b00100;
    bus.rd_enB = 5'b01000;
    for (int k = 0; k < W; k++) apply_stimulus_triple();
    check_output("R2 readback", 32'(bus.product), 143);

    // Non-one-hot read select: err sets, PP keeps the legal 13 rather than 13|11.
    setup_operands(8'd13, 8'd11, 1'b0);
    bus.ppgen_en = 1'b1; tick();
    bus.rd_enA = 5'b00011;
    bus.ppgen_en = 1'b1; tick();
    check_output("bad sel err", 32'(bus.err), 1);
    bus.rd_enA = 5'b00001;
    bus.add_en = 1'b1; tick();
    check_output("bad sel pp held", 32'(bus.product), 3328);
    bus.shift_en = 1'b1; tick();
    for (int k = 0; k < W - 1; k++) apply_stimulus_triple();
    check_output("err sticky product", 32'(bus.product), 143);
    check_output("err sticky", 32'(bus.err), 1);

    // Ninth shift is rejected and ACC holds.
    setup_operands(8'd13, 8'd11, 1'b0);
    for (int k = 0; k < W; k++) apply_stimulus_triple();
    bus.shift_en = 1'b1; tick();
    check_output("ninth shift err", 32'(bus.err), 1);
    check_output("ninth shift product", 32'(bus.product), 143);
    check_output("ninth shift step_done", 32'(bus.step_done), 1);

    // Two strobes in one cycle.
    setup_operands(8'd13, 8'd11, 1'b0);
    bus.ppgen_en = 1'b1; tick();
    bus.add_en = 1'b1;
    bus.shift_en = 1'b1; tick();
    check_output("dual strobe err", 32'(bus.err), 1);
    check_output("dual strobe product", 32'(bus.product), 0);

    // Direction flip mid-multiply; the offending cycle changes nothing.
    setup_operands(8'd13, 8'd11, 1'b0);
    for (int k = 0; k < 3; k++) apply_stimulus_triple();
    check_output("pre flip err", 32'(bus.err), 0);
    bus.left_right = 1'b1; tick();
    check_output("dir flip err", 32'(bus.err), 1);
    bus.left_right = 1'b0;
    for (int k = 0; k < W - 3; k++) apply_stimulus_triple();
    check_output("dir flip product", 32'(bus.product), 143);

    // Asynchronous reset at step 4, then a fresh multiply.
    setup_operands(8'd13, 8'd11, 1'b0);
    for (int k = 0; k < 4; k++) apply_stimulus_triple();
    bus.ld_en = 1'b1;
    bus.ld_sel = 5'b00000;
    tick();
    check_output("pre reset err", 32'(bus.err), 1);
    rst = 1'b0;
    #1;
    check_output("async reset product", 32'(bus.product), 0);
    check_output("async reset step_done", 32'(bus.step_done), 0);
    check_output("async reset err", 32'(bus.err), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.rd_enA = 5'b00001;
    bus.rd_enB = 5'b00010;
    apply_stimulus_load(5'b00001, 8'd7);
    apply_stimulus_load(5'b00010, 8'd9);
    for (int k = 0; k < W; k++) apply_stimulus_triple();
    check_output("post reset product", 32'(bus.product), 63);
    check_output("post reset step_done", 32'(bus.step_done), 1);
    check_output("post reset err", 32'(bus.err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/x_datapath.md
# x_datapath

Shift-add multiplier datapath that executes the per-cycle control strobes issued by the x_fsm controller (register-file read/write selects, partial-product generate, add, shift, direction). It holds operands in a small register file, accumulates the product, reports loop completion back to the controller, and flags protocol violations on a sticky `err`. It sits directly under the multiplier top level, beside x_fsm.

## Interface

- `WIDTH`, 8: operand width in bits; product is 2*WIDTH.
- `NREG`, 5: register-file depth; all select buses are NREG-bit one-hot.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `ld_en` input 1: external load strobe.
- `ld_sel` input NREG: one-hot target register for the load.
- `ld_data` input WIDTH: load data.
- `rd_enA` input NREG: one-hot multiplicand select (operand A); all-zero reads 0.
- `rd_enB` input NREG: one-hot multiplier select (operand B); all-zero reads 0.
- `wr_en` input NREG: one-hot write-back select; writes product low half, then clears the accumulator.
- `ppgen_en` input 1: generate the partial product.
- `add_en` input 1: add the partial product into the accumulator.
- `shift_en` input 1: shift the accumulator and advance the step count.
- `left_right` input 1: 0 = LSB-first (right shift); 1 = MSB-first (left shift).
- `product` output 2*WIDTH: current product view.
- `step_done` output 1: high when step == WIDTH.
- `err` output 1: sticky protocol error.

## Operation

- State:
  - `R[0..NREG-1]`: WIDTH bits each.
  - `PP`: WIDTH bits.
  - `ACC`: 2*WIDTH+1 bits.
  - `step`: 0..WIDTH.
  - `lr_q`: latched direction.
- Multiplier bit: `bsel = B[step]` if `left_right`=0, else `B[WIDTH-1-step]`.
- `ppgen_en`: `PP <= bsel ? A : 0`.
- `add_en`:
  - right mode: `ACC[2W:W] <= ACC[2W-1:W] + PP` (carry into bit 2W).
  - left mode: `ACC <= ACC + PP`.
- `shift_en`:
  - right mode: `ACC <= ACC >> 1`.
  - left mode: `ACC <= ACC << 1` (MSB dropped).
  - Both modes: `step <= step+1`.
- `product` (combinational from ACC):
  - right mode: `ACC[2W-1:0]`.
  - left mode: `ACC[2W:1]`.
- `wr_en`: `R[sel] <= product[W-1:0]`; same edge clears `ACC`, `PP` and `step`.
- `ld_en`: `R[sel] <= ld_data`.
- `lr_q` tracks `left_right` whenever `step`==0.
- Error conditions: each sets `err`, and the offending cycle makes no other state change.
  - `rd_enA`, `rd_enB`, `wr_en` or `ld_sel` neither zero nor one-hot.
  - `ld_en` asserted with `ld_sel` zero.
  - More than one of {`ppgen_en`, `add_en`, `shift_en`, `wr_en`≠0, `ld_en`} in one cycle.
  - `shift_en` with `step`==WIDTH.
  - `left_right` ≠ `lr_q` while `step`≠0.
- `err` clears only on reset.

## Timing

- All state updates on the rising edge of `clk`; `product` and `step_done` reflect registered state with no added latency.
- Reset (asynchronous assert, synchronous release): all R, PP, ACC, step, `lr_q`, `err` = 0; `product`=0, `step_done`=0, `err`=0.
- `PP` written at edge n is usable by `add_en` at edge n+1. Back-to-back strobes are legal.
- One multiply = WIDTH × (ppgen, add, shift) = 3*WIDTH cycles; `step_done` rises the cycle after the final shift. Write-back is one more cycle.
- Register read-during-write (load or write-back to a selected read register): the read returns the old value.
- Reset mid-operation abandons the multiply; registers are lost.

## Structure

- Package `x_mul_pkg`:
  - default `WIDTH`, `NREG`;
  - `onehot0` check function (zero-or-one-hot).
  - The same package is used by x_fsm.
- Sub-module `x_regfile`: NREG×WIDTH, one write port (load or write-back muxed), two one-hot read ports, async active-low reset.
- The top module holds PP/ACC/step, the error checker and the product mux.

## Test plan

- Right mode: load R0=13, R1=11; `rd_enA`=00001, `rd_enB`=00010; 8 ppgen/add/shift triples → `step_done`=1, `product`=143. Then `wr_en`=00100 → R2=143, ACC=0.
- Left mode, same operands → `product`=143 after 24 cycles. Repeat 255×255 → 65025 in both modes.
- B=0 → `product`=0; A=0, B=255 → 0; `step_done` timing unchanged.
- `rd_enA`=00011 with `ppgen_en` → `err`=1 next cycle, PP unchanged. `err` persists through later legal ops until `rst`=0.
- Ninth `shift_en` → `err`=1, ACC unchanged. Simultaneous `add_en`+`shift_en` → `err`=1. Toggling `left_right` at step 3 → `err`=1.
- Assert `rst`=0 at step 4 → all outputs 0 immediately. After release, a fresh 7×9 multiply yields 63.
